// File: rtl/wr_ptr_full_if.sv
// Write-side bus of the asynchronous FIFO: the write request, the read
// pointer already synchronized into the write clock domain, and the
// pointer/flag outputs of wr_ptr_full.
interface wr_ptr_full_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  wr_en;
  logic [ADDR_WIDTH:0]   rd_sync_to_wr;
  logic                  ovf_clr;
  logic                  wr_mem_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wr_level;
  logic                  overflow;

  // Producer side: issues writes and supplies the synchronized read pointer.
  modport master (
    output wr_en, rd_sync_to_wr, ovf_clr,
    input  wr_mem_en, wr_addr, wr_ptr, full, almost_full, wr_level, overflow
  );

  // Pointer/flag logic side.
  modport slave (
    input  wr_en, rd_sync_to_wr, ovf_clr,
    output wr_mem_en, wr_addr, wr_ptr, full, almost_full, wr_level, overflow
  );
endinterface

// File: rtl/wr_ptr_full.sv
// Write-domain pointer and full-flag logic of the asynchronous FIFO.
// Keeps a binary and a Gray write pointer, drives the memory write strobe
// and address, and derives registered full / almost_full / fill level from
// the next-state pointer so flags change on the same edge as wr_ptr.
// Optional feature macro: WR_PTR_LEVEL_EN builds almost_full and wr_level
// (Gray-to-binary converter plus subtractor); without it both are tied to 0.
module wr_ptr_full #(
  parameter int ADDR_WIDTH   = 6,
  parameter int AFULL_THRESH = 60
) (
  input  logic          wr_clk,
  input  logic          wr_rst,
  wr_ptr_full_if.slave  bus
);

  localparam int AW = ADDR_WIDTH;
  localparam int PW = ADDR_WIDTH + 1;

  logic [AW:0] wr_bin_q,  wr_bin_d;
  logic [AW:0] wr_gray_q, wr_gray_d;
  logic        full_q,    full_d;
  logic        ovf_q,     ovf_d;
  logic        wr_accept;
  logic [AW:0] rd_full_cmp;

  // A write is accepted only when the FIFO is not already full.
  assign wr_accept = bus.wr_en & ~full_q;

  // Next-state pointers, full comparison and sticky overflow (set wins).
  always_comb begin
    wr_bin_d    = wr_bin_q + {{AW{1'b0}}, wr_accept};
    wr_gray_d   = (wr_bin_d >> 1) ^ wr_bin_d;
    // Full when the write pointer is one lap ahead: top two Gray bits
    // inverted relative to the read pointer, the rest equal.
    rd_full_cmp = {~bus.rd_sync_to_wr[AW:AW-1], bus.rd_sync_to_wr[AW-2:0]};
    full_d      = (wr_gray_d == rd_full_cmp);
    ovf_d       = (bus.wr_en & full_q) | (ovf_q & ~bus.ovf_clr);
  end

  // Pointer, full and overflow registers.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gray_q <= wr_gray_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.wr_mem_en = wr_accept;
  assign bus.wr_addr   = wr_bin_q[AW-1:0];
  assign bus.wr_ptr    = wr_gray_q;
  assign bus.full      = full_q;
  assign bus.overflow  = ovf_q;

`ifdef WR_PTR_LEVEL_EN
  localparam logic [AW:0] AFULL_TH = PW'(AFULL_THRESH);

  // Gray-to-binary as an XOR prefix running from the MSB down.
  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [AW:0] rd_bin_sync;
  logic [AW:0] level_q, level_d;
  logic        afull_q, afull_d;

  // Fill level from the next-state write pointer; modulo arithmetic
  // handles pointer wrap naturally.
  always_comb begin
    rd_bin_sync = gray2bin(bus.rd_sync_to_wr);
    level_d     = wr_bin_d - rd_bin_sync;
    afull_d     = (level_d >= AFULL_TH);
  end

  // Level and almost-full registers.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      level_q <= '0;
      afull_q <= 1'b0;
    end else begin
      level_q <= level_d;
      afull_q <= afull_d;
    end
  end

  assign bus.almost_full = afull_q;
  assign bus.wr_level    = level_q;
`else
  assign bus.almost_full = 1'b0;
  assign bus.wr_level    = '0;
`endif

endmodule

// File: tb/tb_wr_ptr_full.sv
// Directed bench for wr_ptr_full (ADDR_WIDTH=6, AFULL_THRESH=60): reset,
// fill, overflow, drain, wrap-around streaming and mid-operation reset.
// Expectations for almost_full/wr_level follow WR_PTR_LEVEL_EN.
module tb_wr_ptr_full;

`ifdef WR_PTR_LEVEL_EN
  localparam bit LVL = 1'b1;
`else
  localparam bit LVL = 1'b0;
`endif

  logic wr_clk = 1'b0;
  logic wr_rst = 1'b1;
  int   total  = 0;
  int   bad    = 0;

  wr_ptr_full_if #(.ADDR_WIDTH(6)) bus ();

  wr_ptr_full #(.ADDR_WIDTH(6), .AFULL_THRESH(60)) dut (
    .wr_clk (wr_clk),
    .wr_rst (wr_rst),
    .bus    (bus)
  );

  always #5 wr_clk = ~wr_clk;

  function automatic logic [6:0] gray(input logic [6:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  initial begin
    logic [6:0] p1, p2, prev, cur, x;
    logic [6:0] lvl_exp;
    bit         wrapped;

    // Reset with a pending write: reset must win.
    bus.wr_en = 1'b1;
    bus.rd_sync_to_wr = '0;
    bus.ovf_clr = 1'b0;
    wr_rst = 1'b1;
    tick();
    chk("rst_ptr",   32'(bus.wr_ptr), 32'd0);
    chk("rst_addr",  32'(bus.wr_addr), 32'd0);
    chk("rst_full",  32'(bus.full), 32'd0);
    chk("rst_ovf",   32'(bus.overflow), 32'd0);
    chk("rst_level", 32'(bus.wr_level), 32'd0);
    chk("rst_afull", 32'(bus.almost_full), 32'd0);

    // Fill: 64 writes against an empty read side.
    wr_rst = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      bus.wr_en = 1'b1;
      #1;
      chk("fill_memen", 32'(bus.wr_mem_en), 32'd1);
      tick();
      chk("fill_ptr",   32'(bus.wr_ptr), 32'(gray(7'(i))));
      chk("fill_addr",  32'(bus.wr_addr), 32'(i % 64));
      chk("fill_full",  32'(bus.full), 32'(i == 64));
      chk("fill_afull", 32'(bus.almost_full), 32'(LVL && (i >= 60)));
      chk("fill_level", 32'(bus.wr_level), LVL ? 32'(i) : 32'd0);
    end
    chk("full_ptr", 32'(bus.wr_ptr), 32'h60);

    // Overflow: writes while full are dropped and set the sticky flag.
    bus.wr_en = 1'b1;
    bus.ovf_clr = 1'b0;
    #1;
    chk("ovf_memen", 32'(bus.wr_mem_en), 32'd0);
    tick();
    chk("ovf_set",   32'(bus.overflow), 32'd1);
    chk("ovf_ptr",   32'(bus.wr_ptr), 32'h60);
    chk("ovf_full",  32'(bus.full), 32'd1);
    tick();
    chk("ovf_hold",  32'(bus.overflow), 32'd1);
    chk("ovf_ptr2",  32'(bus.wr_ptr), 32'h60);
    bus.ovf_clr = 1'b1;
    #1;
    chk("ovf_memen3", 32'(bus.wr_mem_en), 32'd0);
    tick();
    chk("ovf_setwins", 32'(bus.overflow), 32'd1);
    chk("ovf_ptr3",    32'(bus.wr_ptr), 32'h60);
    bus.wr_en = 1'b0;
    tick();
    chk("ovf_clr", 32'(bus.overflow), 32'd0);
    chk("ovf_full_kept", 32'(bus.full), 32'd1);
    bus.ovf_clr = 1'b0;

    // Drain: the read pointer advances in the synchronized domain.
    bus.rd_sync_to_wr = 7'b0000001;
    tick();
    chk("drain1_full",  32'(bus.full), 32'd0);
    chk("drain1_level", 32'(bus.wr_level), LVL ? 32'd63 : 32'd0);
    chk("drain1_afull", 32'(bus.almost_full), 32'(LVL));
    bus.rd_sync_to_wr = 7'b0000110;
    tick();
    chk("drain4_level", 32'(bus.wr_level), LVL ? 32'd60 : 32'd0);
    chk("drain4_afull", 32'(bus.almost_full), 32'(LVL));
    bus.rd_sync_to_wr = 7'b0000111;
    tick();
    chk("drain5_level", 32'(bus.wr_level), LVL ? 32'd59 : 32'd0);
    chk("drain5_afull", 32'(bus.almost_full), 32'd0);
    chk("drain5_full",  32'(bus.full), 32'd0);

    // Wrap: 300 writes, read pointer trailing wr_ptr by two edges.
    wr_rst = 1'b1;
    bus.rd_sync_to_wr = '0;
    tick();
    wr_rst = 1'b0;
    p1 = '0;
    p2 = '0;
    prev = '0;
    wrapped = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      bus.wr_en = 1'b1;
      bus.rd_sync_to_wr = p2;
      tick();
      cur = bus.wr_ptr;
      chk("wrap_full", 32'(bus.full), 32'd0);
      chk("wrap_ptr",  32'(cur), 32'(gray(7'(i))));
      x = cur ^ prev;
      chk("wrap_onebit", 32'($countones(x)), 32'd1);
      lvl_exp = (i == 1) ? 7'd1 : 7'd2;
      chk("wrap_level", 32'(bus.wr_level), LVL ? 32'(lvl_exp) : 32'd0);
      if (prev == 7'b1000000 && cur == 7'b0000000) wrapped = 1'b1;
      // p2 is what the synchronizer shows before the next edge.
      p2 = p1;
      p1 = cur;
      prev = cur;
    end
    chk("wrap_seen", 32'(wrapped), 32'd1);

    // Mid-operation reset at level 30.
    bus.wr_en = 1'b0;
    wr_rst = 1'b1;
    bus.rd_sync_to_wr = '0;
    tick();
    wr_rst = 1'b0;
    bus.wr_en = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    chk("mid_level", 32'(bus.wr_level), LVL ? 32'd30 : 32'd0);
    chk("mid_ptr",   32'(bus.wr_ptr), 32'(gray(7'd30)));
    wr_rst = 1'b1;
    tick();
    chk("mid_rst_ptr",   32'(bus.wr_ptr), 32'd0);
    chk("mid_rst_addr",  32'(bus.wr_addr), 32'd0);
    chk("mid_rst_level", 32'(bus.wr_level), 32'd0);
    chk("mid_rst_afull", 32'(bus.almost_full), 32'd0);
    chk("mid_rst_full",  32'(bus.full), 32'd0);
    chk("mid_rst_ovf",   32'(bus.overflow), 32'd0);
    wr_rst = 1'b0;
    bus.wr_en = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wr_ptr_full.md
# wr_ptr_full

Write-side pointer and full-flag logic for the asynchronous FIFO, running entirely in the write clock domain. It keeps a binary and a Gray write pointer, drives the memory write address and write enable, and compares against the read pointer synchronized into the write domain. From that comparison it produces registered `full`, `almost_full` and fill-level outputs, plus a sticky overflow flag. The Gray pointer `wr_ptr` is the value handed to the write-to-read synchronizer.

## Interface
- `ADDR_WIDTH`, 6: memory address width; FIFO depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- `AFULL_THRESH`, 60: fill level at or above which `almost_full` asserts; legal range 1..2^ADDR_WIDTH.
- `wr_clk` input 1: write clock; all logic is on its rising edge.
- `wr_rst` input 1: synchronous, active-high reset.
- `wr_en` input 1: write request.
- `rd_sync_to_wr` input ADDR_WIDTH+1: Gray read pointer, already synchronized into `wr_clk`.
- `ovf_clr` input 1: clears the sticky `overflow` flag.
- `wr_mem_en` output 1: memory write strobe, combinational `wr_en & ~full`.
- `wr_addr` output ADDR_WIDTH: memory write address, `wr_bin[ADDR_WIDTH-1:0]`.
- `wr_ptr` output ADDR_WIDTH+1: registered Gray write pointer.
- `full` output 1: registered full flag.
- `almost_full` output 1: registered threshold flag (macro-gated).
- `wr_level` output ADDR_WIDTH+1: registered fill level, 0..2^ADDR_WIDTH (macro-gated).
- `overflow` output 1: sticky flag set by a write attempt while full.

## Operation
- Pointer style: a binary register `wr_bin` and a Gray register `wr_ptr`.
  - `wr_bin_next = wr_bin + (wr_en & ~full)`, wrapping modulo 2^(ADDR_WIDTH+1).
  - `wr_gray_next = (wr_bin_next >> 1) ^ wr_bin_next`.
  - Both registers load their next values every cycle.
- Full comparison: `full_val = (wr_gray_next == {~rd_sync_to_wr[AW:AW-1], rd_sync_to_wr[AW-2:0]})`, where AW = ADDR_WIDTH.
- Level computation:
  - `rd_bin_sync` = Gray-to-binary of `rd_sync_to_wr`, computed as a combinational XOR prefix from the MSB down.
  - `level_next = wr_bin_next - rd_bin_sync`, modulo 2^(ADDR_WIDTH+1).
- Registered outputs:
  - `full <= full_val`.
  - `almost_full <= (level_next >= AFULL_THRESH)`.
  - `wr_level <= level_next`.
- Overflow flag:
  - Sets when `wr_en & full` is sampled.
  - Clears when `ovf_clr` is sampled.
  - If set and clear occur in the same cycle, set wins.
- A write while full is dropped: the pointer holds and `wr_mem_en` stays 0.
- Flags are pessimistic. The synchronizer delay can hold `full` and `almost_full` asserted for extra cycles after reads. They never deassert early.
- Reset (`wr_rst` high at a clock edge):
  - `wr_bin`, `wr_ptr`, `wr_level` go to 0.
  - `full`, `almost_full`, `overflow` go to 0.
  - Reset overrides `wr_en` and `ovf_clr`.
  - A mid-operation reset discards FIFO contents from the write side. The read side must be reset in the same window; that is system-level responsibility.

## Timing
- Accepted write:
  - Memory is written on the same edge where `wr_mem_en` = 1.
  - `wr_addr`, `wr_ptr` and `wr_level` show the new values from the following cycle.
- `full`, `almost_full` and `wr_level` all derive from next-state values. They change on the same edge as `wr_ptr`, so there is no extra cycle of flag lag.
- Read-side drain: a change on `rd_sync_to_wr` is reflected in `full`, `almost_full` and `wr_level` one edge later.
- Wrap-around: `wr_bin` steps from 2^(AW+1)-1 to 0 with no special handling. For AW=6, Gray goes 7'b1000000 → 7'b0000000.
- Full and write in the same cycle: `wr_mem_en` = 0, the pointer holds, and `overflow` sets on that edge.

## Configuration
- `WR_PTR_LEVEL_EN` defined:
  - `almost_full` and `wr_level` are built as described above, including the Gray-to-binary converter and subtractor.
- `WR_PTR_LEVEL_EN` undefined:
  - `almost_full` is tied to 0 and `wr_level` is tied to 0.
  - The converter and subtractor are not synthesized.
  - `full`, `overflow`, the pointers and `wr_mem_en` behave identically in both builds.

## Test plan
- Reset: assert `wr_rst` with `wr_en` = 1 and `rd_sync_to_wr` = 0 → after the edge, `wr_ptr` = 0, `wr_addr` = 0, `full` = 0, `overflow` = 0, `wr_level` = 0.
- Fill (AW=6): 64 consecutive writes with `rd_sync_to_wr` = 0 →
  - `almost_full` rises after the 60th edge with `wr_level` = 60.
  - `full` rises after the 64th edge with `wr_ptr` = 7'b1100000 and `wr_level` = 64.
- Overflow: from full, hold `wr_en` = 1 for 3 cycles →
  - `wr_mem_en` = 0 and `wr_ptr` unchanged.
  - `overflow` = 1 after the first edge.
  - `ovf_clr` and `wr_en` together keep `overflow` = 1; `ovf_clr` alone clears it.
- Drain: from full, set `rd_sync_to_wr` = 7'b0000001 →
  - Next edge: `full` = 0, `wr_level` = 63, `almost_full` = 1.
  - Then set `rd_sync_to_wr` = Gray(4) = 7'b0000110 → `wr_level` = 60, `almost_full` = 1; Gray(5) = 7'b0000111 → `wr_level` = 59, `almost_full` = 0.
- Wrap: stream 300 writes with `rd_sync_to_wr` tracking `wr_ptr` at 2-cycle delay →
  - `full` is never asserted.
  - `wr_ptr` passes 7'b1000000 → 7'b0000000.
  - Exactly one bit changes per increment.
- Mid-operation reset at level 30 → next cycle all outputs are 0. Rebuild without `WR_PTR_LEVEL_EN` and repeat the fill test → `full` timing is identical, and `almost_full` and `wr_level` stay 0.
